pic_irq_arbiter: RTL

Interrupt request register (IRR), priority resolver and in-service register (ISR) stage of the 8259A-compatible PIC.
- Samples the eight IR pins and latches requests in edge or level mode.
- Resolves the highest-priority unmasked request under rotating priority and presents it one-hot as `interrupt` to the control logic.
- Consumes LTIM, interrupt_mask, freeze, clear_interrupt_request, latch_in_service, EOI and priority_rotate from the control logic.
- Returns highest_level_in_service to the control logic for EOI and rotation decisions.

---
 rtl/pic_pkg.sv | 23 ++
 rtl/pic_priority_pick.sv | 19 +
 rtl/pic_irq_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared constants and rotate/pick helpers for the 8259A-style IRQ arbiter.
package pic_pkg;

    localparam int NUM_IRQ = 8;

    function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} << amount;
        return doubled[15:8];
    endfunction

    // Isolates the lowest set bit; zero stays zero.
    function automatic logic [7:0] priority_pick(input logic [7:0] value);
        return value & (~value + 8'd1);
    endfunction

endpackage

// File: rtl/pic_priority_pick.sv
// Rotating-priority picker: rotates so the highest level sits at bit 0, picks, rotates back.
module pic_priority_pick
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [2:0]         priority_rotate,
    output logic [NUM_IRQ-1:0] pick,
    output logic [NUM_IRQ-1:0] pick_rotated
);

    logic [2:0] amount;

    always_comb begin
        amount       = priority_rotate + 3'd1;
        pick_rotated = priority_pick(rotate_right(vec, amount));
        pick         = rotate_left(pick_rotated, amount);
    end

endmodule

// File: rtl/pic_irq_arbiter.sv
// IRR / priority resolver / ISR stage of the 8259A-compatible PIC.
// Optional macro PIC_SPECIAL_MASK_MODE_EN adds the special_mask_mode input.
module pic_irq_arbiter
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ICW_1,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    input  logic               LTIM,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
    input  logic               latch_in_service,
    input  logic [NUM_IRQ-1:0] EOI,
    input  logic [2:0]         priority_rotate,
`ifdef PIC_SPECIAL_MASK_MODE_EN
    input  logic               special_mask_mode,
`endif
    output logic [NUM_IRQ-1:0] interrupt,
    output logic [NUM_IRQ-1:0] highest_level_in_service,
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic [NUM_IRQ-1:0] in_service_register
);

    logic [NUM_IRQ-1:0] prev_pin;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] irr_next;
    logic [NUM_IRQ-1:0] isr_next;
    logic [NUM_IRQ-1:0] isr_gate;
    logic [NUM_IRQ-1:0] requests;
    logic [NUM_IRQ-1:0] req_pick;
    logic [NUM_IRQ-1:0] req_rotated;
    logic [NUM_IRQ-1:0] isr_pick;
    logic [NUM_IRQ-1:0] isr_rotated;
    logic [NUM_IRQ-1:0] candidate;

    always_comb begin
        rise     = interrupt_request_pin & ~prev_pin;
        requests = interrupt_request_register & ~interrupt_mask;
        isr_gate = in_service_register;
`ifdef PIC_SPECIAL_MASK_MODE_EN
        // Masked in-service levels must not block lower levels in special mask mode.
        if (special_mask_mode)
            isr_gate = in_service_register & ~interrupt_mask;
`endif
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (clear_interrupt_request[i])
                irr_next[i] = 1'b0;
            else if (freeze)
                irr_next[i] = interrupt_request_register[i];
            else if (LTIM)
                irr_next[i] = interrupt_request_pin[i];
            else
                irr_next[i] = interrupt_request_register[i] | rise[i];
        end
        // Lower rotated one-hot value means higher priority.
        if (isr_rotated == '0 || req_rotated < isr_rotated)
            candidate = req_pick;
        else
            candidate = '0;
        isr_next = (in_service_register & ~EOI) | (latch_in_service ? interrupt : '0);
        highest_level_in_service = isr_pick;
    end

    pic_priority_pick u_request_pick (
        .vec             (requests),
        .priority_rotate (priority_rotate),
        .pick            (req_pick),
        .pick_rotated    (req_rotated)
    );

    pic_priority_pick u_in_service_pick (
        .vec             (isr_gate),
        .priority_rotate (priority_rotate),
        .pick            (isr_pick),
        .pick_rotated    (isr_rotated)
    );

    // The PIC core updates on the falling edge of clk.
    always_ff @(negedge clk) begin
        if (reset || ICW_1) begin
            prev_pin                   <= '1;
            interrupt_request_register <= '0;
            in_service_register        <= '0;
            interrupt                  <= '0;
        end else begin
            prev_pin                   <= interrupt_request_pin;
            interrupt_request_register <= irr_next;
            in_service_register        <= isr_next;
            if (!freeze)
                interrupt <= candidate;
        end
    end

endmodule
